// File: rtl/spi_fifo_pkg.sv
// Shared helpers for the SPI staging FIFO: pointer/level width functions,
// parameter sanity predicates and the per-cycle operation encoding.
package spi_fifo_pkg;

  // Pointer width: wraps modulo DEPTH naturally because DEPTH is a power of 2.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Level needs one extra bit so that DEPTH itself is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int ae, input int af);
    return (ae >= 0) && (ae <= depth - 1) && (af >= 1) && (af <= depth);
  endfunction

  // Encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/spi_fifo_mem.sv
// WIDTH x DEPTH storage array for the SPI FIFO: one write port and one
// synchronous read port with enable. Contents are deliberately not reset.
module spi_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-address write this edge is not visible here.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_fifo_param.sv
// Parametrised single-clock FIFO staging SPI TX/RX words. Optional feature:
// define SPI_FIFO_OVERWRITE_EN to make a write while Full replace the oldest entry.
module spi_fifo_param
  import spi_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 12
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic [WIDTH-1:0]          DataIn,
  input  logic                      Write,
  input  logic                      Read,
  input  logic                      Flush,
  input  logic                      ClearOV,
  input  logic                      ClearUF,
  output logic [WIDTH-1:0]          DataOut,
  output logic                      DataValid,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic                      AlmostEmpty,
  output logic [$clog2(DEPTH):0]    Level,
  output logic                      OV,
  output logic                      UF
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);

`ifdef SPI_FIFO_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  if (WIDTH < 1 || DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_size
    $error("spi_fifo_param: WIDTH must be >=1 and DEPTH a power of 2 >= 4");
  end
  if (!thresh_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
    $error("spi_fifo_param: AE_THRESH/AF_THRESH out of range");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_dv;
  logic             r_ov;
  logic             r_uf;
  logic             r_has_data;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_mem_we;
  logic             w_rd_adv;
  logic [WIDTH-1:0] w_mem_rdata;
  fifo_op_e         w_op;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);

  // When Full the FIFO is never Empty, so a concurrent Read always frees a slot.
  assign w_rd_acc  = Read  & ~w_empty & ~Flush;
  assign w_wr_acc  = Write & ~Flush & (~w_full | w_rd_acc);
  assign w_ovf_evt = Write & ~Flush & w_full & ~w_rd_acc;
  assign w_udf_evt = Read  & ~Flush & w_empty;

  assign w_mem_we  = w_wr_acc | (OVERWRITE & w_ovf_evt);
  assign w_rd_adv  = w_rd_acc | (OVERWRITE & w_ovf_evt);
  assign w_op      = fifo_op_e'({w_wr_acc, w_rd_acc});

  spi_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (Clock),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (DataIn),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_dv       <= 1'b0;
      r_has_data <= 1'b0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dv     <= 1'b0;
    end else begin
      if (w_mem_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_acc) r_has_data <= 1'b1;
      r_dv <= w_rd_acc;
      case (w_op)
        OP_WRITE: r_level <= r_level + 1'b1;
        OP_READ:  r_level <= r_level - 1'b1;
        default:  r_level <= r_level;
      endcase
    end
  end

  // A new event in the same cycle as its clear keeps the flag set.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_ov <= 1'b0;
      r_uf <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_ov <= 1'b1;
      else if (ClearOV) r_ov <= 1'b0;
      if (w_udf_evt)    r_uf <= 1'b1;
      else if (ClearUF) r_uf <= 1'b0;
    end
  end

  // The array output is unreset, so mask it to zero until a first read lands.
  assign DataOut     = r_has_data ? w_mem_rdata : '0;
  assign DataValid   = r_dv;
  assign Full        = w_full;
  assign Empty       = w_empty;
  assign AlmostFull  = (r_level >= LVL_AF);
  assign AlmostEmpty = (r_level <= LVL_AE);
  assign Level       = r_level;
  assign OV          = r_ov;
  assign UF          = r_uf;

endmodule
